// File: rtl/memctrl.sv
// memctrl: sequences word-level fetch and load/store requests into 1-4 little-endian byte
// transactions on the unified RAM port, returning results with a one-cycle done pulse.
module memctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        is_send_mem,
  input  logic [31:0] send_addr,
  output logic        is_mem_back,
  output logic [31:0] back_ins,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  output logic        lsb_done,
  output logic [31:0] lsb_ret,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t      r_state;
  logic        r_src;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_data;
  logic [2:0]  r_n;
  logic [2:0]  r_k;
  logic [2:0]  w_len_n;
  logic [5:0]  w_sh;
  logic [31:0] w_asm;
  logic        w_acc_stall;
  logic        w_wr_stall;
  always_comb begin
    w_len_n     = lsb_len == 2'd0 ? 3'd1 : lsb_len == 2'd1 ? 3'd2 : 3'd4;
    w_sh        = 6'd32 - {r_n, 3'b000};
    w_asm       = {mem_din, r_data[31:8]} >> w_sh;
    w_acc_stall = lsb_addr[17:16] == 2'b11 && io_buffer_full;
    w_wr_stall  = r_addr[17:16] == 2'b11 && io_buffer_full;
  end
  assign mem_wr = r_wr & rdy_in;
  // Bytes shift in from the top, so after n captures the result sits in the top n bytes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_src       <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_data      <= 32'd0;
      r_n         <= 3'd0;
      r_k         <= 3'd0;
      mem_a       <= 32'd0;
      mem_dout    <= 8'd0;
      is_mem_back <= 1'b0;
      back_ins    <= 32'd0;
      lsb_done    <= 1'b0;
      lsb_ret     <= 32'd0;
    end else if (rdy_in) begin
      is_mem_back <= 1'b0;
      lsb_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          mem_a  <= 32'd0;
          r_wr   <= 1'b0;
          r_data <= 32'd0;
          r_k    <= 3'd1;
          if (lsb_req) begin
            r_src  <= 1'b1;
            r_addr <= lsb_addr;
            r_n    <= w_len_n;
            if (!lsb_wr) begin
              mem_a   <= lsb_addr;
              r_state <= READ;
            end else if (w_acc_stall) begin
              r_k     <= 3'd0;
              r_wdata <= lsb_data;
              r_state <= WRITE;
            end else begin
              r_wr     <= 1'b1;
              mem_a    <= lsb_addr;
              mem_dout <= lsb_data[7:0];
              r_wdata  <= lsb_data >> 8;
              r_state  <= WRITE;
            end
          end else if (is_send_mem) begin
            r_src   <= 1'b0;
            r_addr  <= send_addr;
            r_n     <= 3'd4;
            mem_a   <= send_addr;
            r_state <= READ;
          end
        end
        READ: begin
          // Park the address at 0 once issued so IO-mapped reads are never repeated.
          mem_a <= r_k < r_n ? r_addr + {29'd0, r_k} : 32'd0;
          r_k   <= r_k + 3'd1;
          if (r_k >= 3'd2) r_data <= {mem_din, r_data[31:8]};
          if (r_k == r_n + 3'd1) begin
            r_state <= IDLE;
            if (r_src) begin
              lsb_done <= 1'b1;
              lsb_ret  <= w_asm;
            end else begin
              is_mem_back <= 1'b1;
              back_ins    <= w_asm;
            end
          end
        end
        WRITE: begin
          if (r_k == r_n) begin
            r_wr     <= 1'b0;
            mem_a    <= 32'd0;
            lsb_done <= 1'b1;
            r_state  <= IDLE;
          end else if (w_wr_stall) begin
            r_wr  <= 1'b0;
            mem_a <= 32'd0;
          end else begin
            r_wr     <= 1'b1;
            mem_a    <= r_addr + {29'd0, r_k};
            mem_dout <= r_wdata[7:0];
            r_wdata  <= r_wdata >> 8;
            r_k      <= r_k + 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: directed and randomized checks of memctrl against a byte-array memory model.
module tb_memctrl;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, is_send_mem, lsb_req, lsb_wr, io_buffer_full;
  logic [31:0] send_addr, lsb_addr, lsb_data;
  logic [1:0]  lsb_len;
  logic [7:0]  mem_din;
  logic        is_mem_back, lsb_done, mem_wr;
  logic [31:0] back_ins, lsb_ret, mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  ram [0:1048575];
  logic [7:0]  gm  [0:1048575];
  int checks = 0;
  int errors = 0;

  memctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .is_send_mem(is_send_mem), .send_addr(send_addr),
    .is_mem_back(is_mem_back), .back_ins(back_ins),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_len(lsb_len),
    .lsb_addr(lsb_addr), .lsb_data(lsb_data),
    .lsb_done(lsb_done), .lsb_ret(lsb_ret),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] v;
    case (i)
      'h100: return 8'h13;
      'h101: return 8'h05;
      'h102: return 8'h10;
      'h103: return 8'h00;
      default: begin
        v = (i * 37) ^ (i >> 7);
        return v[7:0];
      end
    endcase
  endfunction

  // RAM with one cycle of read latency, stalled by the same enable
  initial begin
    for (int i = 0; i < 1048576; i++) ram[i] = init_byte(i);
    forever begin
      @(posedge clk_in);
      if (rdy_in) begin
        if (mem_wr) ram[mem_a[19:0]] = mem_dout;
        mem_din <= ram[mem_a[19:0]];
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] v, t;
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      t = a + 32'(i);
      v[8*i +: 8] = gm[t[19:0]];
    end
    return v;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = a + 32'(i);
      gm[t[19:0]] = d[8*i +: 8];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_done(input string tag, input bit ok);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s: observed no completion expected completion", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // One request with optional IO stall cycles (s) and an rdy_in pause starting at edge 3.
  task automatic xact(input bit fetch, input bit wr, input logic [1:0] len, input logic [31:0] addr,
                      input logic [31:0] data, input int s, input int pause, output logic [31:0] ret);
    int n, lim, fz, eff;
    bit ok, d, o;
    logic [31:0] exp;
    n   = fetch ? 4 : len == 2'd0 ? 1 : len == 2'd1 ? 2 : 4;
    lim = wr ? n + s : n + 1;
    exp = model_read(addr, n);
    ret = 32'd0;
    ok  = 1'b0;
    if (fetch) begin
      is_send_mem = 1'b1;
      send_addr   = addr;
    end else begin
      lsb_req  = 1'b1;
      lsb_wr   = wr;
      lsb_len  = len;
      lsb_addr = addr;
      lsb_data = data;
    end
    io_buffer_full = s > 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      cyc();
      fz  = (pause == 0 || k < 3) ? 0 : (k - 2 < pause ? k - 2 : pause);
      eff = k - fz;
      rdy_in = !(pause > 0 && k + 1 >= 3 && k + 1 < 3 + pause);
      io_buffer_full = k + 1 < s;
      d = fetch ? is_mem_back : lsb_done;
      o = fetch ? lsb_done : is_mem_back;
      check("other_done", {31'd0, o}, 32'd0);
      check("done_timing", {31'd0, d}, {31'd0, eff == lim});
      if (!rdy_in) check("paused_wr", {31'd0, mem_wr}, 32'd0);
      if (!wr && eff < n) begin
        check("rd_addr", mem_a, addr + 32'(eff));
        check("rd_wr", {31'd0, mem_wr}, 32'd0);
      end
      if (wr && eff < s) check("stall_wr", {31'd0, mem_wr}, 32'd0);
      if (wr && eff >= s && eff - s < n) begin
        check("wr_strobe", {31'd0, mem_wr}, 32'd1);
        check("wr_addr", mem_a, addr + 32'(eff - s));
        check("wr_byte", {24'd0, mem_dout}, {24'd0, data[8*(eff-s) +: 8]});
      end
      if (eff == lim) begin
        if (wr) check("wr_end", {31'd0, mem_wr}, 32'd0);
        else begin
          ret = fetch ? back_ins : lsb_ret;
          check(fetch ? "fetch_data" : "load_data", ret, exp);
        end
        ok = 1'b1;
        is_send_mem = 1'b0;
        lsb_req = 1'b0;
        io_buffer_full = 1'b0;
        rdy_in = 1'b1;
      end
    end
    check_done("xact_timeout", ok);
    if (wr) model_write(addr, data, n);
  endtask

  initial begin
    logic [31:0] r, el, ef, a, dd;
    logic [1:0] ln;
    bit ok;
    int op, s;
    rst_in = 1'b1; rdy_in = 1'b1; is_send_mem = 1'b0; lsb_req = 1'b0; lsb_wr = 1'b0;
    io_buffer_full = 1'b0; send_addr = 32'd0; lsb_addr = 32'd0; lsb_data = 32'd0; lsb_len = 2'd0;
    for (int i = 0; i < 1048576; i++) gm[i] = init_byte(i);
    repeat (2) cyc();
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_back", {31'd0, is_mem_back}, 32'd0);
    check("rst_back_ins", back_ins, 32'd0);
    check("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    check("rst_lsb_ret", lsb_ret, 32'd0);
    rst_in = 1'b0;
    cyc();

    xact(1, 0, 2'd2, 32'h100, 32'd0, 0, 0, r);
    check("fetch_const", r, 32'h00100513);

    // LSB wins the tie; the fetch is taken the edge after lsb_done
    el = model_read(32'h200, 4);
    ef = model_read(32'h104, 4);
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd2; lsb_addr = 32'h200;
    is_send_mem = 1'b1; send_addr = 32'h104;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cyc();
      check("sim_lsb_done", {31'd0, lsb_done}, {31'd0, k == 5});
      check("sim_back", {31'd0, is_mem_back}, {31'd0, k == 11});
      if (k == 5) begin
        check("sim_lsb_ret", lsb_ret, el);
        lsb_req = 1'b0;
      end
      if (k == 11) begin
        check("sim_back_ins", back_ins, ef);
        is_send_mem = 1'b0;
        ok = 1'b1;
      end
    end
    check_done("sim_timeout", ok);

    xact(0, 1, 2'd1, 32'h300, 32'hAABBCCDD, 0, 0, r);
    xact(0, 0, 2'd0, 32'h301, 32'd0, 0, 0, r);
    check("ld301_const", r, 32'h000000CC);
    xact(0, 0, 2'd0, 32'h302, 32'd0, 0, 0, r);
    check("ld302_untouched", r, {24'd0, init_byte('h302)});

    xact(0, 1, 2'd0, 32'h30000, 32'h41, 3, 0, r);
    xact(0, 0, 2'd0, 32'h30000, 32'd0, 0, 0, r);
    check("io_byte", r, 32'h41);

    // Reset lands while byte 2 of a word store is on the bus
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd2; lsb_addr = 32'h400; lsb_data = 32'h11223344;
    repeat (3) cyc();
    check("mid_wr", {31'd0, mem_wr}, 32'd1);
    check("mid_addr", mem_a, 32'h402);
    check("mid_byte", {24'd0, mem_dout}, 32'h22);
    rst_in = 1'b1;
    lsb_req = 1'b0;
    cyc();
    rst_in = 1'b0;
    check("rst2_wr", {31'd0, mem_wr}, 32'd0);
    check("rst2_done", {31'd0, lsb_done}, 32'd0);
    check("rst2_addr", mem_a, 32'd0);
    check("rst2_dout", {24'd0, mem_dout}, 32'd0);
    model_write(32'h400, 32'h11223344, 3);
    repeat (3) begin
      cyc();
      check("rst2_quiet_done", {31'd0, lsb_done}, 32'd0);
      check("rst2_quiet_wr", {31'd0, mem_wr}, 32'd0);
    end
    xact(1, 0, 2'd2, 32'h100, 32'd0, 0, 0, r);
    check("fetch_after_rst", r, 32'h00100513);
    xact(0, 0, 2'd2, 32'h400, 32'd0, 0, 0, r);

    xact(1, 0, 2'd2, 32'h104, 32'd0, 0, 4, r);
    xact(1, 0, 2'd2, 32'hFFFFFFFE, 32'd0, 0, 0, r);

    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      ln = 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 'hFFF0);
      dd = $urandom;
      s  = 0;
      if (op == 2 && $urandom_range(0, 3) == 0) begin
        a = 32'h30000 | a;
        s = $urandom_range(0, 3);
      end
      xact(op == 0, op == 2, ln, a, dd, s, 0, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
